// File: rtl/led_io_pkg.sv
// Shared definitions for board-level I/O conditioning blocks: debounce FSM
// state encoding, default timing constants and a counter-width helper.
package led_io_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } db_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1_250_000;   // 10 ms at 125 MHz
  localparam int DEF_LONG_CYCLES   = 125_000_000; // 1 s at 125 MHz

  // Bits needed to hold the larger of two cycle counts without overflow.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input; the output is
// the last flop of the chain. Reusable for any board input.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour and the chain shifts one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizes the raw button, accepts level changes
// only after a stable window, and emits press/release/long-press strobes.
module btn_debounce
  import led_io_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, LONG_CYCLES);
  // The cycle that detects a change in S_LOW/S_HIGH is the first stable
  // cycle, so the candidate state accepts when its counter hits STABLE-2.
  localparam logic [CNT_W-1:0] STABLE_LAST =
    CNT_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYCLES);

  logic             btn_s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             level_d, press_d, release_d, long_d;
  logic [7:0]       count_d;
  logic             accept_press, accept_release;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_btn),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q       <= S_LOW;
      cnt_q         <= '0;
      hold_q        <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      press_count   <= count_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hold_d         = hold_q;
    level_d        = btn_level;
    press_d        = 1'b0;
    release_d      = 1'b0;
    long_d         = 1'b0;
    count_d        = press_count;
    accept_press   = 1'b0;
    accept_release = 1'b0;

    case (state_q)
      S_LOW: begin
        if (btn_s) begin
          // A one-cycle window is already satisfied by the detecting cycle.
          if (STABLE_CYCLES == 1) begin
            accept_press = 1'b1;
          end else begin
            state_d = S_RISE;
            cnt_d   = '0;
          end
        end
      end
      S_RISE: begin
        if (!btn_s)                    state_d = S_LOW;
        else if (cnt_q == STABLE_LAST) accept_press = 1'b1;
        else                           cnt_d = cnt_q + 1'b1;
      end
      S_HIGH: begin
        if (!btn_s) begin
          if (STABLE_CYCLES == 1) begin
            accept_release = 1'b1;
          end else begin
            state_d = S_FALL;
            cnt_d   = '0;
          end
        end
      end
      S_FALL: begin
        if (btn_s)                     state_d = S_HIGH;
        else if (cnt_q == STABLE_LAST) accept_release = 1'b1;
        else                           cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_LOW;
    endcase

    // Hold counter saturates at LONG_CYCLES, so the strobe cannot repeat.
    if (btn_level) begin
      if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
      if (hold_q == HOLD_LAST && !accept_release) long_d = 1'b1;
    end

    if (accept_press) begin
      state_d = S_HIGH;
      level_d = 1'b1;
      press_d = 1'b1;
      hold_d  = '0;
      count_d = press_count + 8'd1;
    end
    if (accept_release) begin
      state_d   = S_LOW;
      level_d   = 1'b0;
      release_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (SYNC_STAGES=2, STABLE_CYCLES=4,
// LONG_CYCLES=10, 8 ns clock): vector table plus multi-cycle sequences.
module tb_btn_debounce;

  logic       clk;
  logic       rst_btn;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  btn_debounce #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .LONG_CYCLES   (10)
  ) dut (
    .clk           (clk),
    .rst_btn       (rst_btn),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  initial clk = 1'b0;
  always #4ns clk = ~clk;

  typedef struct {
    bit rst;
    bit btn;
    bit level;
    bit press;
    bit rel;
    bit lng;
    int cnt;
  } vec_t;

  vec_t vecs[$];

  int np, nr, nl, nboth;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void add(bit rst, bit btn, bit level, bit press, bit rel, int cnt);
    vecs.push_back('{rst, btn, level, press, rel, 1'b0, cnt});
  endfunction

  function automatic logic [11:0] outs();
    return {btn_level, press_pulse, release_pulse, long_pulse, press_count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1ns;
  endtask

  task automatic tally_step();
    step();
    if (press_pulse) np++;
    if (release_pulse) nr++;
    if (long_pulse) nl++;
    if (press_pulse && release_pulse) nboth++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_btn = 1'b0;
    btn_in  = 1'b0;
    #2ns;
    check("reset_outputs", outs(), 12'h000);
    @(negedge clk);
    rst_btn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int nlong;
    int long_at;

    rst_btn = 1'b0;
    btn_in  = 1'b0;

    // Clean press accepted 6 cycles after the edge, then a short press release.
    add(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1);
    for (int i = 0; i < 2; i++) add(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    // Bounce on press, then a one-cycle release glitch that must be rejected.
    add(1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 1);
    add(0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 0, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      btn_in = vecs[i].btn;
      step();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].lng, 8'(vecs[i].cnt)});
    end

    // Long press: long strobe 10 cycles after the press strobe, exactly once.
    do_reset();
    @(negedge clk);
    btn_in = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!press_pulse && lat < 20);
    check("long_press_latency", lat, 6);
    nlong = 0;
    long_at = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (long_pulse) begin nlong++; long_at = k; end
    end
    check("long_pulse_count", nlong, 1);
    check("long_pulse_at", long_at, 10);
    check("long_level_held", btn_level, 1);
    @(negedge clk);
    btn_in = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
      if (long_pulse) nlong++;
    end while (!release_pulse && lat < 20);
    check("long_release_latency", lat, 6);
    check("long_pulse_after_release", nlong, 1);
    step();
    check("long_level_released", btn_level, 0);

    // 256 clean presses wrap the counter back to zero.
    do_reset();
    np = 0; nr = 0; nl = 0; nboth = 0;
    for (int p = 0; p < 256; p++) begin
      @(negedge clk);
      btn_in = 1'b1;
      repeat (7) tally_step();
      @(negedge clk);
      btn_in = 1'b0;
      repeat (8) tally_step();
      if (p == 254) check("wrap_count_255", press_count, 255);
    end
    check("wrap_count_0", press_count, 0);
    check("wrap_press_strobes", np, 256);
    check("wrap_release_strobes", nr, 256);
    check("wrap_no_long", nl, 0);
    check("wrap_no_overlap", nboth, 0);

    // Reset while pressed clears asynchronously; held button is re-accepted.
    do_reset();
    @(negedge clk);
    btn_in = 1'b1;
    repeat (8) step();
    check("midreset_pressed", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
    @(negedge clk);
    #1ns;
    rst_btn = 1'b0;
    #1ns;
    check("midreset_async_clear", outs(), 12'h000);
    @(negedge clk);
    rst_btn = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!press_pulse && lat < 20);
    check("midreset_press_latency", lat, 6);
    check("midreset_count", press_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on btn_in (legal >= 2).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 1_250_000 (10 ms at 125 MHz), consecutive stable cycles required to accept a level change (legal >= 1).
REQ-003 The block SHALL have parameter LONG_CYCLES, default 125_000_000 (1 s at 125 MHz), debounced-high duration that qualifies a long press (legal >= 1).
REQ-004 Port: clk, input, 1, single clock for all logic, 125 MHz nominal (8 ns).
REQ-005 Port: rst_btn, input, 1, asynchronous active-low reset.
REQ-006 Port: btn_in, input, 1, raw mechanical button, asynchronous to clk, active-high when pressed.
REQ-007 Port: btn_level, output, 1, debounced button level.
REQ-008 Port: press_pulse, output, 1, one-cycle strobe on accepted press.
REQ-009 Port: release_pulse, output, 1, one-cycle strobe on accepted release.
REQ-010 Port: long_pulse, output, 1, one-cycle strobe when a press reaches LONG_CYCLES.
REQ-011 Port: press_count, output, 8, count of accepted presses, wraps 255 -> 0.

Function
REQ-012 btn_in SHALL pass through a SYNC_STAGES flop chain; its last stage is btn_s; no other logic SHALL sample btn_in.
REQ-013 The FSM SHALL have states S_LOW (stable released), S_RISE (candidate press), S_HIGH (stable pressed), S_FALL (candidate release).
REQ-014 S_LOW: btn_s=1 -> S_RISE with stability counter cleared; else stay.
REQ-015 S_RISE: btn_s=0 -> S_LOW, no outputs change (glitch rejected); btn_s=1 for STABLE_CYCLES consecutive cycles -> S_HIGH.
REQ-016 S_HIGH: btn_s=0 -> S_FALL with stability counter cleared; else stay.
REQ-017 S_FALL: btn_s=1 -> S_HIGH, no outputs change; btn_s=0 for STABLE_CYCLES consecutive cycles -> S_LOW.
REQ-018 On S_RISE->S_HIGH, btn_level SHALL go 1 and press_pulse SHALL be 1 for exactly one cycle, both registered, in the same cycle.
REQ-019 On S_FALL->S_LOW, btn_level SHALL go 0 and release_pulse SHALL be 1 for exactly one cycle.
REQ-020 Latency from a clean btn_in edge to btn_level/strobe SHALL be exactly SYNC_STAGES + STABLE_CYCLES clock cycles.
REQ-021 A hold counter SHALL clear on press acceptance, increment every cycle while btn_level=1 (including S_FALL), and saturate.
REQ-022 long_pulse SHALL fire exactly once per press, in the cycle the hold counter reaches LONG_CYCLES; never if release is accepted first.
REQ-023 press_count SHALL increment by 1 in the cycle press_pulse is high; 255 SHALL wrap to 0.
REQ-024 Counter widths SHALL be $clog2(max(STABLE_CYCLES, LONG_CYCLES)+1); no counter SHALL overflow.
REQ-025 At most one of press_pulse/release_pulse SHALL be high in any cycle.

Reset
REQ-026 rst_btn=0 SHALL asynchronously force: synchronizer flops 0, state S_LOW, all counters 0, btn_level 0, all pulses 0, press_count 0.
REQ-027 Reset release SHALL take effect on the next clk rising edge; no pulse SHALL be emitted on that edge.
REQ-028 Reset mid-press: button still held after release SHALL be accepted as a new press after the full REQ-020 latency, incrementing press_count from 0.

Structure
REQ-029 State encodings (S_LOW=0, S_RISE=1, S_HIGH=2, S_FALL=3) and default timing constants SHALL live in shared package led_io_pkg.
REQ-030 The synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, async active-low reset), reusable for other board inputs.

Verification (bench params: SYNC_STAGES=2, STABLE_CYCLES=4, LONG_CYCLES=10; 8 ns clock)
REQ-031 Clean press: btn_in 0->1 held -> btn_level=1 and press_pulse one cycle, 6 cycles after edge; press_count 0->1.
REQ-032 Bounce: btn_in high 3 cycles, low 1, then high held -> no pulse during bounce; press_pulse 6 cycles after final rise; press_count=1.
REQ-033 Long press: hold 20 cycles past acceptance -> long_pulse once, 10 cycles after press_pulse; then release -> release_pulse 6 cycles after falling edge.
REQ-034 Short press: accept press, release after 3 debounced cycles -> release_pulse, no long_pulse.
REQ-035 Wrap: 256 clean presses -> press_count returns to 0, exactly 256 press_pulse strobes.
REQ-036 Reset mid-press: rst_btn low while btn_level=1 -> all outputs 0 immediately (async); release reset with btn_in held -> press_pulse 6 cycles later, press_count=1.
